// File: rtl/uart_tx_ctrl_if.sv
// Bus interface for uart_tx_ctrl.
// Carries one single-cycle request/response access per clock.
//   req_i  : access request
//   we_i   : 1 = write, 0 = read
//   addr_i : byte address
//   data_i : write data
//   data_o : read data, combinational from the slave
// The master modport is the bus requester, and the slave modport is the UART.
interface uart_tx_ctrl_if;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;

   modport master (output req_i, output we_i, output addr_i, output data_i, input data_o);
   modport slave  (input req_i, input we_i, input addr_i, input data_i, output data_o);
endinterface

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and a programmable baud divisor.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous reset, active-high
//   bus   : register access interface (slave modport); reads are combinational
//   tx_o  : serial output, idle high, registered
//   irq_o : level interrupt, raised when irq_en is set, the FIFO is empty and the shifter is idle
// Register window at BASE_ADDR:
//   0x0 CTRL
//   0x4 STATUS
//   0x8 BAUD
//   0xC TXDATA
module uart_tx_ctrl #(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd434
) (
   input  logic            clk,
   input  logic            rst,
   uart_tx_ctrl_if.slave   bus,
   output logic            tx_o,
   output logic            irq_o
);

   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic [1:0]    ctrl_q;
   logic [15:0]   baud_q;
   logic          ovr_q;
   logic [AW:0]   cnt_q;
   logic [AW-1:0] wptr_q, rptr_q;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [15:0]   timer_q, div_q;
   logic [7:0]    shift_q;
   logic [2:0]    bit_q;
   logic          tx_q, tx_d, irq_q;

   logic          sel, wr, rd, full, empty, busy, push_req, push, pop, tick;
   logic [1:0]    idx;
   logic          unused;

   assign sel      = bus.req_i && (bus.addr_i[31:4] == BASE_ADDR[31:4]);
   assign wr       = sel && bus.we_i;
   assign rd       = sel && !bus.we_i;
   assign idx      = bus.addr_i[3:2];
   assign full     = (cnt_q == DEPTH);
   assign empty    = (cnt_q == '0);
   assign busy     = (state_q != IDLE);
   assign push_req = wr && (idx == 2'd3);
   // A push is judged on the pre-edge count, so a simultaneous pop never rescues it.
   assign push     = push_req && !full;
   assign tick     = (timer_q == '0);
   assign unused   = ^{bus.data_i[31:16], bus.addr_i[1:0]};

   // Control and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q <= 2'b01;
         baud_q <= DIV_RESET;
         ovr_q  <= 1'b0;
      end else begin
         if (wr && idx == 2'd0) ctrl_q <= bus.data_i[1:0];
         if (wr && idx == 2'd2) baud_q <= (bus.data_i[15:0] < 16'd2) ? 16'd2 : bus.data_i[15:0];
         if (push_req && full) ovr_q <= 1'b1;
         else if (wr && idx == 2'd1 && bus.data_i[2]) ovr_q <= 1'b0;
      end
   end

   // FIFO storage.
   always_ff @(posedge clk) begin
      if (push) mem[wptr_q] <= bus.data_i[7:0];
   end

   // FIFO pointers and count. The pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (pop) state_d = START;
         START: if (tick) state_d = DATA;
         DATA:  if (tick && bit_q == 3'd7) state_d = STOP;
         STOP:  if (tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: the pop strobe and the line level for the current state.
   always_comb begin
      pop  = 1'b0;
      tx_d = 1'b1;
      case (state_q)
         IDLE:  pop  = ctrl_q[0] && !empty;
         START: tx_d = 1'b0;
         DATA:  tx_d = shift_q[0];
         default: tx_d = 1'b1;
      endcase
   end

   // The bit timer, shifter and output registers. tx_o lags the state by one cycle,
   // which places the start edge two cycles after the push edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q <= '0;
         div_q   <= '0;
         shift_q <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
         irq_q   <= 1'b0;
      end else begin
         tx_q  <= tx_d;
         irq_q <= ctrl_q[1] && empty && !busy;
         if (pop) begin
            shift_q <= mem[rptr_q];
            div_q   <= baud_q;
            timer_q <= baud_q - 16'd1;
            bit_q   <= '0;
         end else if (busy) begin
            if (tick) begin
               timer_q <= div_q - 16'd1;
               if (state_q == DATA) begin
                  shift_q <= {1'b0, shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
               end
            end else begin
               timer_q <= timer_q - 16'd1;
            end
         end
      end
   end

   // Zero-latency read mux.
   always_comb begin
      bus.data_o = '0;
      if (rd) begin
         case (idx)
            2'd0: bus.data_o = {30'b0, ctrl_q};
            2'd1: bus.data_o = {19'b0, 5'(cnt_q), 4'b0, busy, ovr_q, empty, full};
            2'd2: bus.data_o = {16'b0, baud_q};
            default: bus.data_o = '0;
         endcase
      end
   end

   assign tx_o  = tx_q;
   assign irq_o = irq_q;

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Memory-mapped UART transmitter that sits directly downstream of the core's ID-send logic on the data bus. It accepts byte writes into a TX FIFO, serialises them as 8N1 frames on tx_o at a programmable baud rate, and exposes a status word at BASE+0x4. The sender polls that status word and writes only when bit0 (FIFO full) is 0.

Parameters:
BASE_ADDR, 32'h3000_0000, base of the 16-byte register window
FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, range 2..16
DIV_RESET, 16'd434, reset baud divisor in clk cycles per bit (50 MHz / 115200)

Ports:
clk     input   1   system clock, rising edge
rst     input   1   asynchronous reset, active-high
req_i   input   1   bus access request
we_i    input   1   1 = write, 0 = read
addr_i  input   32  byte address
data_i  input   32  write data
data_o  output  32  read data, combinational
tx_o    output  1   serial output, idle high
irq_o   output  1   level interrupt: FIFO empty and shifter idle, gated by CTRL bit1

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Register decode: the block is selected when req_i=1 and addr_i[31:4]==BASE_ADDR[31:4]. The register is chosen by addr_i[3:2]. Accesses outside the window are ignored and data_o=0.
- Register map:
  - 0x0 CTRL (RW): bit0 tx_en, bit1 irq_en. Reset value 0x1.
  - 0x4 STATUS (RO except bit2): bit0 full, bit1 empty, bit2 overrun (sticky, cleared by writing 1 to bit2), bit3 busy (shifter active), bits[12:8] FIFO count. All other bits read 0.
  - 0x8 BAUD (RW): bits[15:0] divisor. A write of 0 or 1 stores 2.
  - 0xC TXDATA (WO, reads 0): a write pushes data_i[7:0].
- Reads: data_o reflects current register state in the same cycle (zero latency). data_o=0 when req_i=0 or we_i=1.
- Writes: take effect on the rising clk edge. The first write that returns STATUS bit0=0 is guaranteed acceptance.
- FIFO push and pop:
  - A TXDATA push when the count equals FIFO_DEPTH is dropped, and overrun is set.
  - Fullness is judged on the pre-edge count. A push while full is dropped even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle with 0<count<DEPTH leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Shifter FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. If tx_en=1 and the FIFO is not empty, pop the head into the shift register, latch the divisor into the bit timer, and go to START on the next cycle.
  - START: tx_o=0 for DIV cycles.
  - DATA: tx_o=shift[0] for DIV cycles per bit. Bits go out LSB first. A bit counter runs 0..7; after bit 7, go to STOP.
  - STOP: tx_o=1 for DIV cycles, then return to IDLE.
  - Back-to-back frames: IDLE re-evaluates in the cycle after STOP ends, so the minimum inter-frame idle is 1 cycle.
  - busy=1 in every state except IDLE.
- Timing: from a TXDATA write into an empty FIFO with the shifter idle and tx_en=1, the falling start edge appears 2 clk cycles after the write edge. A full frame lasts 10×DIV cycles.
- Divisor changes: a BAUD write mid-frame does not affect the current frame. The new value applies from the next frame.
- tx_en cleared mid-frame: the current frame completes normally, and no new frame starts while tx_en=0. FIFO contents are retained.
- Reset (also mid-frame): state returns to IDLE, tx_o=1, FIFO is emptied, count=0, overrun=0, CTRL=0x1, BAUD=DIV_RESET, data_o=0, irq_o=0.
- irq_o = irq_en & empty & ~busy, registered; it updates one cycle after the condition changes.

Test Plan:
- Reset values: assert rst asynchronously between clock edges. Required: tx_o=1 immediately, STATUS read 0x0000_0002, BAUD read 434, CTRL read 0x1.
- Single byte, BAUD=4: write 0x32 to 0x3000000C. Required: tx_o goes low 2 cycles later and then carries 0,0,1,0,0,1,1,0,0,1 with 4 cycles per bit. STATUS bit3 returns to 0 after 40 cycles.
- Overrun: BAUD=100, tx_en=0, then 9 pushes 0x30..0x38. Required: STATUS count=8, bit0=1, bit2=1; the byte 0x38 is absent. Writing 1 to STATUS bit2 clears overrun.
- ID string, BAUD=2: poll STATUS and push the bytes 0x32,0x30,0x32,0x33,0x32,0x31,0x31,0x30,0x31,0x33 whenever bit0=0. Required: 10 frames in order, gaps between frames of at most 1 cycle while the FIFO is non-empty, and irq_o=1 (irq_en=1) after the last stop bit.
- Mid-frame reset: assert rst during DATA bit 3. Required: tx_o=1 within the same cycle and the FIFO empty. After release, no residual frame is emitted.
- Simultaneous push and pop: with the FIFO at count=8, push while IDLE pops. Required: the push is dropped, overrun=1, and count=7. With count=3, push and pop in the same cycle leave count=3.
